// File: rtl/chargen.sv
// Cyclic character generator: steps a registered 8-bit character from INITCHAR
// to LASTCHAR and wraps. A chip-select advances it and a write strobe restarts it.
module chargen #(
    parameter logic [7:0] INITCHAR = 8'h61,
    parameter logic [7:0] LASTCHAR = 8'h63
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       n_cs,
    input  logic       n_wr,
    output logic [7:0] port
);

    if (INITCHAR > LASTCHAR) begin : g_bad_range
        $error("chargen: INITCHAR must not exceed LASTCHAR");
    end

    logic [7:0] char_r;
    logic [7:0] next_s;

    // Next-character selection; out-of-range or unknown values fall back to INITCHAR
    always_comb begin
        next_s = char_r;
        if (n_cs == 1'b1) begin
            if (n_wr == 1'b1) begin
                next_s = INITCHAR;
            end else if ((char_r >= INITCHAR) && (char_r < LASTCHAR)) begin
                next_s = char_r + 8'd1;
            end else begin
                next_s = INITCHAR;
            end
        end else begin
            next_s = char_r;
        end
    end

    // Character register with synchronous reset
    always_ff @(posedge clk) begin
        if (n_rst == 1'b1) begin
            char_r <= INITCHAR;
        end else begin
            char_r <= next_s;
        end
    end

    assign port = char_r;

endmodule

// File: tb/tb_chargen.sv
// Self-checking bench for chargen: directed steps plus randomized traffic, three
// parameterisations compared against an arithmetic sequence model.
module tb_chargen;

    logic       clk;
    logic       rst;
    logic       cs;
    logic       wr;
    logic [7:0] port_a;
    logic [7:0] port_d;
    logic [7:0] port_x;

    logic [7:0] exp_a;
    logic [7:0] exp_d;
    logic [7:0] exp_x;

    int checks;
    int failures;

    chargen u_alpha (
        .clk   (clk),
        .n_rst (rst),
        .n_cs  (cs),
        .n_wr  (wr),
        .port  (port_a)
    );

    chargen #(.INITCHAR(8'h30), .LASTCHAR(8'h39)) u_digit (
        .clk   (clk),
        .n_rst (rst),
        .n_cs  (cs),
        .n_wr  (wr),
        .port  (port_d)
    );

    chargen #(.INITCHAR(8'h78), .LASTCHAR(8'h78)) u_const (
        .clk   (clk),
        .n_rst (rst),
        .n_cs  (cs),
        .n_wr  (wr),
        .port  (port_x)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sequence viewed as an index into [init..last], advanced modulo its length
    function automatic logic [7:0] model_next(input logic [7:0] cur, input logic [7:0] init,
                                              input logic [7:0] last, input logic r,
                                              input logic c, input logic w);
        int span;
        int pos;
        span = int'(last) - int'(init) + 1;
        pos  = int'(cur) - int'(init);
        if (r) return init;
        if (!c) return cur;
        if (w) return init;
        if (pos < 0 || pos >= span) return init;
        return 8'(int'(init) + ((pos + 1) % span));
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic r, input logic c, input logic w, input string tag);
        rst = r;
        cs  = c;
        wr  = w;
        @(posedge clk);
        #1;
        exp_a = model_next(exp_a, 8'h61, 8'h63, r, c, w);
        exp_d = model_next(exp_d, 8'h30, 8'h39, r, c, w);
        exp_x = model_next(exp_x, 8'h78, 8'h78, r, c, w);
        check({tag, "_alpha"}, port_a, exp_a);
        check({tag, "_digit"}, port_d, exp_d);
        check({tag, "_const"}, port_x, exp_x);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b0;
        cs  = 1'b0;
        wr  = 1'b0;
        exp_a = 8'h00;
        exp_d = 8'h00;
        exp_x = 8'h00;
        @(negedge clk);

        // Reset pulse, then idle
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_a = 8'h61;
        exp_d = 8'h30;
        exp_x = 8'h78;
        check("reset_alpha", port_a, 8'h61);
        check("reset_digit", port_d, 8'h30);
        check("reset_const", port_x, 8'h78);
        step(1'b0, 1'b0, 1'b0, "reset_idle");
        check("reset_idle_a", port_a, 8'h61);

        // Advance with wrap: b c a b c
        step(1'b0, 1'b1, 1'b0, "adv1");
        check("adv1_b", port_a, 8'h62);
        step(1'b0, 1'b1, 1'b0, "adv2");
        check("adv2_c", port_a, 8'h63);
        step(1'b0, 1'b1, 1'b0, "adv3");
        check("adv3_wrap_a", port_a, 8'h61);
        step(1'b0, 1'b1, 1'b0, "adv4");
        check("adv4_b", port_a, 8'h62);
        step(1'b0, 1'b1, 1'b0, "adv5");
        check("adv5_c", port_a, 8'h63);

        // Soft restart from c, then advance to b
        step(1'b0, 1'b1, 1'b1, "restart");
        check("restart_a", port_a, 8'h61);
        step(1'b0, 1'b1, 1'b0, "restart_adv");
        check("restart_adv_b", port_a, 8'h62);

        // Hold from b with n_wr toggling
        step(1'b0, 1'b0, 1'b1, "hold1");
        step(1'b0, 1'b0, 1'b0, "hold2");
        step(1'b0, 1'b0, 1'b1, "hold3");
        check("hold_b", port_a, 8'h62);

        // Reset overrides a simultaneous advance
        step(1'b1, 1'b1, 1'b0, "rst_prio");
        check("rst_prio_a", port_a, 8'h61);
        step(1'b1, 1'b1, 1'b1, "rst_prio_wr");
        check("rst_prio_wr_a", port_a, 8'h61);

        // Digit sweep: 12 advances from '0' lands on '2'
        step(1'b1, 1'b0, 1'b0, "sweep_rst");
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 1'b0, "sweep");
        end
        check("sweep_digit_2", port_d, 8'h32);
        check("sweep_alpha_a", port_a, 8'h61);
        check("sweep_const_x", port_x, 8'h78);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0,
                 "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/chargen.md
CHARGEN -- requirements
Module: chargen

Interface
REQ-001 Parameter INITCHAR, default "a" (8'h61): first character of the sequence and the reset value of port.
REQ-002 Parameter LASTCHAR, default "c" (8'h63): last character of the sequence, after which the sequence wraps.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 n_rst  input  1  reset; synchronous, active-high.
REQ-005 n_cs  input  1  chip select / advance request; asserted = 1.
REQ-006 n_wr  input  1  write strobe (restart request); asserted = 1; meaningful only while n_cs = 1.
REQ-007 port  output  8  current character, registered, driven at all times.
REQ-008 Parameter legality: INITCHAR <= LASTCHAR, both 8-bit; a violation shall be flagged at elaboration (simulation error) and is not synthesizable.

Function
REQ-009 State: one 8-bit character register; port shall equal this register directly, with no combinational path from any input to port.
REQ-010 Priority per rising edge: n_rst, then (n_cs & n_wr), then n_cs alone, then hold.
REQ-011 n_rst = 1 at an edge: register <= INITCHAR, regardless of n_cs and n_wr.
REQ-012 n_cs = 1, n_wr = 1, n_rst = 0: register <= INITCHAR (soft restart), independent of the current value.
REQ-013 n_cs = 1, n_wr = 0, n_rst = 0, register < LASTCHAR: register <= register + 1.
REQ-014 n_cs = 1, n_wr = 0, n_rst = 0, register == LASTCHAR: register <= INITCHAR (wrap-around).
REQ-015 Out-of-range register value (> LASTCHAR or < INITCHAR, e.g. X or power-up garbage) with n_cs = 1, n_wr = 0: register <= INITCHAR.
REQ-016 n_cs = 0, n_rst = 0: register holds; n_wr is ignored.
REQ-017 Latency: one advance per rising edge while n_cs is held high, so holding n_cs high for N edges advances the sequence N steps modulo (LASTCHAR - INITCHAR + 1).
REQ-018 Degenerate case INITCHAR == LASTCHAR: port is constant INITCHAR after reset.
REQ-019 Arithmetic: 8-bit unsigned; the +1 never overflows, because the wrap of REQ-014 applies first.

Reset
REQ-020 Before the first reset edge, port is undefined; no power-up value is required.
REQ-021 After the first rising edge with n_rst = 1, port = INITCHAR and stays there until n_rst returns to 0 and an advance occurs.
REQ-022 Reset asserted mid-sequence returns port to INITCHAR at the next edge, overriding a simultaneous n_cs or n_wr.

Verification
REQ-023 Reset: pulse n_rst 0 -> 1 -> 0 (one cycle each), n_cs = 0 -> port = "a".
REQ-024 Advance with wrap: from "a", hold n_cs = 1 for 5 edges -> port sequence b, c, a, b, c; final port = "c".
REQ-025 Hold: from "b", n_cs = 0 and n_wr toggled for 3 edges -> port stays "b".
REQ-026 Soft restart: from "c", one edge with n_cs = 1 and n_wr = 1 -> port = "a"; then one edge with n_cs = 1 and n_wr = 0 -> "b".
REQ-027 Reset priority: from "b", one edge with n_rst = 1 and n_cs = 1 -> port = "a" (not "c").
REQ-028 Parameter sweep: INITCHAR = "0", LASTCHAR = "9", n_cs held for 12 edges -> port = "2".
